pe_vec: RTL and testbench

Parametrised multi-lane successor to the scalar PE. Each of LANES lanes runs a signed multiply-accumulate on its own x/weight pair. All lanes share one uop stream and one output handshake. Supported operations: accumulate, bias add, arithmetic right-shift requantise, optional ReLU, and illegal-uop detection. The block sits between the operand fetch stage and the output writeback buffer of the conv datapath.

---
 rtl/pe_vec.sv | 117 +++++++++++
 tb/tb_pe_vec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec.sv
// pe_vec: LANES-wide signed multiply-accumulate PE with bias, requantise shift and ReLU.
// Define PE_SAT_EN to make the AW->DW narrowing saturate instead of wrapping.
module pe_vec #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int AW    = 40,
  parameter int SHW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  out_en,
  input  logic                  calc_bias,
  input  logic                  calc_relu,
  input  logic [SHW-1:0]        shift,
  input  logic [LANES*DW-1:0]   x,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [LANES*DW-1:0]   bias,
  output logic [LANES*DW-1:0]   result_r,
  output logic                  out_valid_r,
  input  logic                  out_ready,
  output logic                  illegal_uop
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t state_reg, state_next;
  logic   accept, mac_uop, fin_uop, bad_uop;

  // flush overrides every uop, including the illegal-uop check
  assign accept  = in_ready && !flush;
  assign fin_uop = accept && in_valid && out_en;
  assign mac_uop = accept && in_valid && !out_en && !calc_bias;
  assign bad_uop = accept && ((!in_valid && (out_en || calc_bias)) ||
                              (in_valid && calc_bias && !out_en));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      out_valid_r <= 1'b0;
      illegal_uop <= 1'b0;
    end else begin
      state_reg   <= state_next;
      out_valid_r <= (state_next == S_OUT);
      illegal_uop <= bad_uop;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE, S_ACC: begin
          if (fin_uop)      state_next = S_OUT;
          else if (mac_uop) state_next = S_ACC;
        end
        S_OUT: if (out_valid_r && out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_reg != S_OUT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DW-1:0]   x_lane, w_lane, b_lane;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   prod_ext, bias_ext, bias_term, sum, acc_reg;
      logic signed [DW-1:0]   narrowed, final_val, result_reg;

      assign x_lane    = x[gi*DW +: DW];
      assign w_lane    = weight[gi*DW +: DW];
      assign b_lane    = bias[gi*DW +: DW];
      assign prod      = (2*DW)'(x_lane) * (2*DW)'(w_lane);
      assign prod_ext  = AW'(prod);
      assign bias_ext  = AW'(b_lane);
      assign bias_term = calc_bias ? bias_ext : '0;
      // calc_bias is 0 on every accepted plain MAC, so sum also serves the accumulate path
      assign sum       = acc_reg + prod_ext + bias_term;

`ifdef PE_SAT_EN
      logic signed [AW-1:0] shifted;
      logic                 in_range;
      assign shifted  = sum >>> shift;
      assign in_range = (&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]);
      assign narrowed = in_range ? shifted[DW-1:0]
                      : (shifted[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
`else
      assign narrowed = DW'(sum >>> shift);
`endif

      assign final_val = (calc_relu && narrowed[DW-1]) ? '0 : narrowed;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg    <= '0;
          result_reg <= '0;
        end else begin
          if (flush || fin_uop) acc_reg <= '0;
          else if (mac_uop)     acc_reg <= sum;
          if (fin_uop)          result_reg <= final_val;
        end
      end

      assign result_r[gi*DW +: DW] = result_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pe_vec.sv
// Directed table-driven bench for pe_vec plus hand sequences for illegal uops,
// backpressure, flush and asynchronous reset.
module tb_pe_vec;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AW    = 40;
  localparam int SHW   = 5;
  localparam int NV    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, flush, out_en, calc_bias, calc_relu, out_ready;
  logic [SHW-1:0]      shift;
  logic [LANES*DW-1:0] x, weight, bias, result_r;
  logic                in_ready, out_valid_r, illegal_uop;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int n;
    int xv[LANES];
    int wv[LANES];
    int bv[LANES];
    int sh;
    bit cb;
    bit relu;
    int ev[LANES];
  } vec_t;

  vec_t vt[NV];

  always #5 clk = ~clk;

  pe_vec #(.LANES(LANES), .DW(DW), .AW(AW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_en(out_en), .calc_bias(calc_bias), .calc_relu(calc_relu), .shift(shift),
    .x(x), .weight(weight), .bias(bias), .result_r(result_r),
    .out_valid_r(out_valid_r), .out_ready(out_ready), .illegal_uop(illegal_uop)
  );

  task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                     input logic [LANES*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    in_valid = 0; out_en = 0; calc_bias = 0; calc_relu = 0; flush = 0; shift = '0;
  endtask

  task automatic set_all(input int xv, input int wv, input int bv);
    for (int i = 0; i < LANES; i++) begin
      x[i*DW +: DW]      = DW'(xv);
      weight[i*DW +: DW] = DW'(wv);
      bias[i*DW +: DW]   = DW'(bv);
    end
  endtask

  function automatic logic [LANES*DW-1:0] splat(input int v);
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic mac(input int n);
    in_valid = 1; out_en = 0; calc_bias = 0;
    repeat (n) tick();
    idle_ctl();
  endtask

  task automatic final_uop(input bit cb, input bit relu, input int sh);
    in_valid = 1; out_en = 1; calc_bias = cb; calc_relu = relu; shift = SHW'(sh);
    tick();
    idle_ctl();
  endtask

  task automatic pop(input string name);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({name, " pop out_valid"}, out_valid_r, 0);
    chk({name, " pop in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [LANES*DW-1:0] ep;
    logic [LANES*DW-1:0] held;

    vt[0] = '{32, '{1,1,1,1}, '{1,1,1,1}, '{5,5,5,5}, 0, 1'b1, 1'b0, '{38,38,38,38}};
    vt[1] = '{4, '{-3,2,0,-1}, '{7,2,0,1}, '{9,9,9,9}, 0, 1'b0, 1'b1, '{0,20,0,0}};
`ifdef PE_SAT_EN
    vt[2] = '{3, '{32767,-32768,1,1}, '{32767,32767,1,1}, '{0,0,0,0}, 0, 1'b0, 1'b0,
              '{32767,-32768,4,4}};
`else
    vt[2] = '{3, '{32767,-32768,1,1}, '{32767,32767,1,1}, '{0,0,0,0}, 0, 1'b0, 1'b0,
              '{4,0,4,4}};
`endif
    vt[3] = '{0, '{16,-16,7,-7}, '{16,16,1,1}, '{100,100,100,100}, 4, 1'b0, 1'b0,
              '{16,-16,0,-1}};
    vt[4] = '{2, '{3,3,3,3}, '{-2,-2,-2,-2}, '{-10,30,0,-32768}, 1, 1'b1, 1'b0,
              '{-14,6,-9,-16393}};

    rst = 1; out_ready = 0;
    idle_ctl();
    set_all(0, 0, 0);
    tick(); tick();
    chk("reset result_r", result_r, 0);
    chk("reset out_valid", out_valid_r, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset illegal", illegal_uop, 0);
    rst = 0;
    tick();

    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < LANES; i++) begin
        x[i*DW +: DW]      = DW'(vt[k].xv[i]);
        weight[i*DW +: DW] = DW'(vt[k].wv[i]);
        bias[i*DW +: DW]   = DW'(vt[k].bv[i]);
        ep[i*DW +: DW]     = DW'(vt[k].ev[i]);
      end
      mac(vt[k].n);
      final_uop(vt[k].cb, vt[k].relu, vt[k].sh);
      chk($sformatf("v%0d out_valid", k), out_valid_r, 1);
      chk($sformatf("v%0d in_ready", k), in_ready, 0);
      chk($sformatf("v%0d result", k), result_r, ep);
      pop($sformatf("v%0d", k));
    end

    // illegal uops leave the partial sum intact
    set_all(1, 1, 7);
    mac(32);
    out_en = 1; calc_bias = 1;
    tick(); idle_ctl();
    chk("ill1 pulse", illegal_uop, 1);
    chk("ill1 out_valid", out_valid_r, 0);
    chk("ill1 in_ready", in_ready, 1);
    tick();
    chk("ill1 pulse end", illegal_uop, 0);
    in_valid = 1; calc_bias = 1;
    tick(); idle_ctl();
    chk("ill2 pulse", illegal_uop, 1);
    tick();
    chk("ill2 pulse end", illegal_uop, 0);
    set_all(1, 1, 0);
    final_uop(0, 0, 0);
    chk("ill result", result_r, splat(33));
    pop("ill");

    // backpressure: uops offered in OUT are ignored and raise no illegal flag
    set_all(2, 3, 0);
    final_uop(0, 0, 0);
    held = result_r;
    chk("bp result", held, splat(6));
    set_all(5, 5, 5);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; calc_bias = (c % 2 == 1); out_en = (c == 4);
      tick();
      chk($sformatf("bp%0d in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d stable", c), result_r, held);
      chk($sformatf("bp%0d illegal", c), illegal_uop, 0);
    end
    idle_ctl();
    pop("bp");
    chk("bp hold after pop", result_r, held);
    set_all(1, 1, 0);
    final_uop(0, 0, 0);
    chk("bp next result", result_r, splat(1));
    pop("bp next");

    // flush mid-accumulation, with a concurrent final uop that must be dropped
    mac(10);
    in_valid = 1; out_en = 1; calc_bias = 1; flush = 1;
    tick(); idle_ctl();
    chk("flush acc out_valid", out_valid_r, 0);
    chk("flush acc in_ready", in_ready, 1);
    chk("flush acc illegal", illegal_uop, 0);
    mac(3);
    final_uop(0, 0, 0);
    chk("flush acc result", result_r, splat(4));
    pop("flush acc");

    // flush while a result is pending
    set_all(3, 3, 0);
    final_uop(0, 0, 0);
    chk("flush out pre", result_r, splat(9));
    flush = 1;
    tick(); idle_ctl();
    chk("flush out out_valid", out_valid_r, 0);
    chk("flush out in_ready", in_ready, 1);
    chk("flush out result held", result_r, splat(9));
    set_all(1, 1, 0);
    mac(3);
    final_uop(0, 0, 0);
    chk("flush out result", result_r, splat(4));
    pop("flush out");

    // asynchronous reset between edges drops a pending result
    mac(5);
    final_uop(0, 0, 0);
    chk("arst pre", result_r, splat(6));
    #2 rst = 1;
    #1;
    chk("arst result", result_r, 0);
    chk("arst out_valid", out_valid_r, 0);
    chk("arst in_ready", in_ready, 1);
    #1 rst = 0;
    tick();
    mac(5);
    #2 rst = 1;
    #2 rst = 0;
    tick();
    final_uop(0, 0, 0);
    chk("arst acc cleared", result_r, splat(1));
    pop("arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
